// File: rtl/ncl_pkg.sv
// Shared NCL dual-rail types, code constants and operation select.
// Helpers classify a single dual-rail bit as NULL, DATA or illegal.
package ncl_pkg;

  typedef struct packed {
    logic rail1;
    logic rail0;
  } dual_rail_logic;

  localparam dual_rail_logic NULL_DR  = 2'b00;
  localparam dual_rail_logic DATA0_DR = 2'b01;
  localparam dual_rail_logic DATA1_DR = 2'b10;

  typedef enum logic [1:0] {
    OP_AND,
    OP_OR,
    OP_XOR
  } op_t;

  function automatic logic dr_is_data(dual_rail_logic v);
    return v.rail1 ^ v.rail0;
  endfunction

  function automatic logic dr_is_null(dual_rail_logic v);
    return ~(v.rail1 | v.rail0);
  endfunction

  function automatic logic dr_is_illegal(dual_rail_logic v);
    return v.rail1 & v.rail0;
  endfunction

endpackage

// File: rtl/ncl_bit_gate.sv
// One dual-rail result bit: per-rail threshold set terms plus hysteresis registers.
// Latency 1 clk; a rail sets only while ki_i=1 and clears only once ki_i=0 and both inputs are NULL.
module ncl_bit_gate
  import ncl_pkg::*;
#(
  parameter op_t OP = OP_AND
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  dual_rail_logic x_i,
  input  dual_rail_logic y_i,
  input  logic           ki_i,
  output dual_rail_logic z_o,
  output logic           illegal_o
);

  dual_rail_logic set_c;
  dual_rail_logic z_d, z_q;
  logic           inputs_null;

  always_comb begin
    set_c = NULL_DR;
    case (OP)
      OP_AND: begin
        set_c.rail1 = x_i.rail1 & y_i.rail1;
        set_c.rail0 = (x_i.rail0 & y_i.rail0) | (y_i.rail0 & x_i.rail1) | (x_i.rail0 & y_i.rail1);
      end
      OP_OR: begin
        set_c.rail1 = (x_i.rail1 & y_i.rail1) | (x_i.rail1 & y_i.rail0) | (x_i.rail0 & y_i.rail1);
        set_c.rail0 = x_i.rail0 & y_i.rail0;
      end
      OP_XOR: begin
        set_c.rail1 = (x_i.rail1 & y_i.rail0) | (x_i.rail0 & y_i.rail1);
        set_c.rail0 = (x_i.rail0 & y_i.rail0) | (x_i.rail1 & y_i.rail1);
      end
      default: set_c = NULL_DR;
    endcase
  end

  assign illegal_o   = dr_is_illegal(x_i) | dr_is_illegal(y_i);
  assign inputs_null = dr_is_null(x_i) & dr_is_null(y_i);

  // An illegal operand freezes both rails until the inputs are legal again.
  always_comb begin
    z_d = z_q;
    if (!illegal_o) begin
      if (ki_i) begin
        if (set_c.rail1) z_d.rail1 = 1'b1;
        if (set_c.rail0) z_d.rail0 = 1'b1;
      end else if (inputs_null) begin
        z_d = NULL_DR;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      z_q <= NULL_DR;
    end else begin
      z_q <= z_d;
    end
  end

  assign z_o = z_q;

endmodule

// File: rtl/ncl_gate_vec.sv
// WIDTH-bit dual-rail gate vector with completion FSM, sticky err and wavefront counter.
// z lags inputs by 1 clk; ko/done/wave_cnt react to the registered z one edge later.
module ncl_gate_vec
  import ncl_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter op_t         OP    = OP_AND,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*WIDTH-1:0] x,
  input  logic [2*WIDTH-1:0] y,
  input  logic               ki,
  output logic [2*WIDTH-1:0] z,
  output logic               ko,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   wave_cnt
);

  typedef enum logic {
    WAIT_DATA,
    WAIT_NULL
  } cd_state_t;

  dual_rail_logic   z_w [WIDTH];
  logic [WIDTH-1:0] bit_data;
  logic [WIDTH-1:0] bit_null;
  logic [WIDTH-1:0] bit_bad;
  logic [WIDTH-1:0] in_bad;
  logic             all_data;
  logic             all_null;

  cd_state_t        state_q;
  logic             ko_q;
  logic             done_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    ncl_bit_gate #(
      .OP(OP)
    ) u_gate (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .x_i      (x[2*gi +: 2]),
      .y_i      (y[2*gi +: 2]),
      .ki_i     (ki),
      .z_o      (z_w[gi]),
      .illegal_o(in_bad[gi])
    );

    assign z[2*gi +: 2] = z_w[gi];
    assign bit_data[gi] = dr_is_data(z_w[gi]);
    assign bit_null[gi] = dr_is_null(z_w[gi]);
    assign bit_bad[gi]  = dr_is_illegal(z_w[gi]);
  end

  assign all_data = &bit_data;
  assign all_null = &bit_null;

  // Completion is judged on the registered z, so ko/done trail z by one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WAIT_DATA;
      ko_q    <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= err_q | (|in_bad) | (|bit_bad);
      case (state_q)
        WAIT_DATA: begin
          if (all_data) begin
            state_q <= WAIT_NULL;
            ko_q    <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        WAIT_NULL: begin
          if (all_null) begin
            state_q <= WAIT_DATA;
            ko_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= WAIT_DATA;
          ko_q    <= 1'b1;
        end
      endcase
    end
  end

  assign ko       = ko_q;
  assign done     = done_q;
  assign err      = err_q;
  assign wave_cnt = cnt_q;

endmodule

// File: tb/tb_ncl_gate_vec.sv
// Bench for ncl_gate_vec: AND/OR/XOR instances plus a 2-bit-counter AND instance,
// directed cases then randomized wavefronts against a value-level reference model.
module tb_ncl_gate_vec;
  import ncl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [5:0] x;
  logic [5:0] y;
  logic       ki;

  logic [5:0] z_w    [4];
  logic       ko_w   [4];
  logic       done_w [4];
  logic       err_w  [4];
  logic [7:0] cnt_w  [3];
  logic [1:0] cnt_c2;

  int n_chk;
  int n_fail;

  // reference model state, per instance (0 AND, 1 OR, 2 XOR, 3 AND with 2-bit counter)
  logic [5:0] zm [4];
  bit         ph [4];
  int         cm [4];
  bit         dm [4];
  bit         em [4];

  ncl_gate_vec #(.WIDTH(3), .OP(OP_AND), .CNT_W(8)) dut_and (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .ki(ki), .z(z_w[0]), .ko(ko_w[0]),
    .done(done_w[0]), .err(err_w[0]), .wave_cnt(cnt_w[0]));
  ncl_gate_vec #(.WIDTH(3), .OP(OP_OR), .CNT_W(8)) dut_or (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .ki(ki), .z(z_w[1]), .ko(ko_w[1]),
    .done(done_w[1]), .err(err_w[1]), .wave_cnt(cnt_w[1]));
  ncl_gate_vec #(.WIDTH(3), .OP(OP_XOR), .CNT_W(8)) dut_xor (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .ki(ki), .z(z_w[2]), .ko(ko_w[2]),
    .done(done_w[2]), .err(err_w[2]), .wave_cnt(cnt_w[2]));
  ncl_gate_vec #(.WIDTH(3), .OP(OP_AND), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .ki(ki), .z(z_w[3]), .ko(ko_w[3]),
    .done(done_w[3]), .err(err_w[3]), .wave_cnt(cnt_c2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] enc(input logic [2:0] v, input logic [2:0] mask);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < 3; i++)
      if (mask[i]) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  // Value-level behaviour of one output bit: both operands DATA under ki=1 adds the
  // rail of the Boolean result; both NULL under ki=0 empties it; illegal freezes it.
  function automatic logic [1:0] bit_next(input int op, input logic [1:0] zq,
                                          input logic [1:0] a, input logic [1:0] b, input logic k);
    logic r;
    if (a == 2'b11 || b == 2'b11) return zq;
    if (k) begin
      if (a != 2'b00 && b != 2'b00) begin
        if (op == 0)      r = a[1] & b[1];
        else if (op == 1) r = a[1] | b[1];
        else              r = a[1] ^ b[1];
        return zq | (r ? 2'b10 : 2'b01);
      end
      return zq;
    end
    if (a == 2'b00 && b == 2'b00) return 2'b00;
    return zq;
  endfunction

  task automatic model_tick();
    for (int k = 0; k < 4; k++) begin
      int  op;
      int  modv;
      bit  alld;
      bit  bad;
      op   = (k == 1) ? 1 : (k == 2) ? 2 : 0;
      modv = (k == 3) ? 4 : 256;
      if (!rst_n) begin
        zm[k] = '0; ph[k] = 0; cm[k] = 0; dm[k] = 0; em[k] = 0;
      end else begin
        alld = 1; bad = 0;
        for (int i = 0; i < 3; i++) begin
          if (zm[k][2*i +: 2] != 2'b01 && zm[k][2*i +: 2] != 2'b10) alld = 0;
          if (zm[k][2*i +: 2] == 2'b11 || x[2*i +: 2] == 2'b11 || y[2*i +: 2] == 2'b11) bad = 1;
        end
        dm[k] = 0;
        if (bad) em[k] = 1;
        if (!ph[k] && alld) begin
          ph[k] = 1; dm[k] = 1; cm[k] = (cm[k] + 1) % modv;
        end else if (ph[k] && zm[k] == 6'd0) begin
          ph[k] = 0;
        end
        for (int i = 0; i < 3; i++)
          zm[k][2*i +: 2] = bit_next(op, zm[k][2*i +: 2], x[2*i +: 2], y[2*i +: 2], ki);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    @(negedge clk);
  endtask

  task automatic check_all(input string tag);
    logic [7:0] c;
    for (int k = 0; k < 4; k++) begin
      c = (k == 3) ? {6'd0, cnt_c2} : cnt_w[k];
      chk($sformatf("%s_z%0d", tag, k), 32'(z_w[k]), 32'(zm[k]));
      chk($sformatf("%s_ko%0d", tag, k), 32'(ko_w[k]), 32'(!ph[k]));
      chk($sformatf("%s_done%0d", tag, k), 32'(done_w[k]), 32'(dm[k]));
      chk($sformatf("%s_err%0d", tag, k), 32'(err_w[k]), 32'(em[k]));
      chk($sformatf("%s_cnt%0d", tag, k), 32'(c), 32'(cm[k]));
    end
  endtask

  task automatic stepc(input string tag);
    step();
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ki = 1'b0; x = '0; y = '0;
    stepc("rst");
    rst_n = 1'b1;
  endtask

  // full wavefront: data then null, returns the 2-bit count seen on the done cycle
  task automatic wave(input logic [2:0] a, input logic [2:0] b, output logic [1:0] c2_done,
                      output logic d2_done);
    ki = 1'b1; x = enc(a, 3'b111); y = enc(b, 3'b111);
    stepc("wd1");
    stepc("wd2");
    c2_done = cnt_c2;
    d2_done = done_w[3];
    ki = 1'b0; x = '0; y = '0;
    stepc("wn1");
    stepc("wn2");
  endtask

  initial begin
    logic [31:0] r;
    logic [2:0]  a, b, mx, my;
    logic [1:0]  c2;
    logic        d2;
    int          seq [5];
    n_chk = 0; n_fail = 0;
    seq = '{1, 2, 3, 0, 1};
    rst_n = 1'b0; ki = 1'b0; x = '0; y = '0;

    // reset state
    stepc("rst0");
    stepc("rst1");
    chk("rst_z", 32'(z_w[0]), 32'd0);
    chk("rst_ko", 32'(ko_w[0]), 32'd1);
    chk("rst_cnt", 32'(cnt_w[0]), 32'd0);
    rst_n = 1'b1;

    // AND 101 & 011
    ki = 1'b1; x = enc(3'b101, 3'b111); y = enc(3'b011, 3'b111);
    stepc("and1");
    chk("and_z", 32'(z_w[0]), 32'h16);
    chk("and_ko_pre", 32'(ko_w[0]), 32'd1);
    stepc("and2");
    chk("and_ko", 32'(ko_w[0]), 32'd0);
    chk("and_done", 32'(done_w[0]), 32'd1);
    chk("and_cnt", 32'(cnt_w[0]), 32'd1);
    ki = 1'b0; x = '0; y = '0;
    stepc("null1");
    chk("null_z", 32'(z_w[0]), 32'd0);
    chk("null_ko_hold", 32'(ko_w[0]), 32'd0);
    stepc("null2");
    chk("null_ko", 32'(ko_w[0]), 32'd1);
    chk("null_done", 32'(done_w[0]), 32'd0);

    // partial arrival: x bit 2 late
    ki = 1'b1; x = enc(3'b101, 3'b011); y = enc(3'b011, 3'b111);
    stepc("part1");
    stepc("part2");
    chk("part_z2", 32'(z_w[0][5:4]), 32'd0);
    chk("part_ko", 32'(ko_w[0]), 32'd1);
    chk("part_done", 32'(done_w[0]), 32'd0);
    x = enc(3'b101, 3'b111);
    stepc("part3");
    chk("part_z", 32'(z_w[0]), 32'h16);
    stepc("part4");
    chk("part_done2", 32'(done_w[0]), 32'd1);
    chk("part_cnt", 32'(cnt_w[0]), 32'd2);
    ki = 1'b0; x = '0; y = '0;
    stepc("partn1");
    stepc("partn2");

    // XOR / OR on 110, 011
    ki = 1'b1; x = enc(3'b110, 3'b111); y = enc(3'b011, 3'b111);
    stepc("xo1");
    chk("xor_z", 32'(z_w[2]), 32'h26);
    chk("or_z", 32'(z_w[1]), 32'h2a);
    stepc("xo2");
    ki = 1'b0; x = '0; y = '0;
    stepc("xon1");
    stepc("xon2");

    // illegal operand on bit 0
    do_reset();
    ki = 1'b1; x = {enc(3'b101, 3'b110)} | 6'b000011; y = enc(3'b011, 3'b111);
    stepc("ill1");
    chk("ill_err", 32'(err_w[0]), 32'd1);
    chk("ill_z0", 32'(z_w[0][1:0]), 32'd0);
    ki = 1'b0; x = '0; y = '0;
    stepc("illn1");
    stepc("illn2");
    wave(3'b111, 3'b010, c2, d2);
    chk("ill_err_sticky", 32'(err_w[0]), 32'd1);
    do_reset();
    chk("ill_err_clr", 32'(err_w[0]), 32'd0);

    // 2-bit counter wrap, then reset in WAIT_NULL
    for (int i = 0; i < 5; i++) begin
      r = $urandom;
      wave(r[2:0], r[5:3], c2, d2);
      chk($sformatf("wrap_done%0d", i), 32'(d2), 32'd1);
      chk($sformatf("wrap_cnt%0d", i), 32'(c2), 32'(seq[i]));
    end
    ki = 1'b1; x = enc(3'b001, 3'b111); y = enc(3'b100, 3'b111);
    stepc("wn_a");
    stepc("wn_b");
    chk("wn_ko", 32'(ko_w[3]), 32'd0);
    do_reset();
    chk("wn_rst_z", 32'(z_w[3]), 32'd0);
    chk("wn_rst_ko", 32'(ko_w[3]), 32'd1);
    chk("wn_rst_cnt", 32'(cnt_c2), 32'd0);

    // reset mid-wavefront aborts it
    ki = 1'b1; x = enc(3'b110, 3'b111); y = enc(3'b101, 3'b111);
    stepc("ab1");
    do_reset();
    stepc("ab2");
    chk("ab_done", 32'(done_w[0]), 32'd0);
    chk("ab_cnt", 32'(cnt_w[0]), 32'd0);

    // randomized protocol wavefronts with staggered bit arrival/departure
    for (int w = 0; w < 40; w++) begin
      r = $urandom;
      a = r[2:0]; b = r[5:3]; mx = '0; my = '0;
      ki = 1'b1;
      for (int s = 0; s < 4; s++) begin
        r = $urandom;
        mx = (s == 3) ? 3'b111 : (mx | r[2:0]);
        my = (s == 3) ? 3'b111 : (my | r[5:3]);
        x = enc(a, mx); y = enc(b, my);
        stepc("rd");
      end
      stepc("rd_done");
      ki = 1'b0;
      for (int s = 0; s < 4; s++) begin
        r = $urandom;
        mx = (s == 3) ? 3'b000 : (mx & r[2:0]);
        my = (s == 3) ? 3'b000 : (my & r[5:3]);
        x = enc(a, mx); y = enc(b, my);
        stepc("rn");
      end
      stepc("rn_done");
    end

    // unconstrained inputs, including illegal codes and mid-wavefront changes
    for (int s = 0; s < 150; s++) begin
      r = $urandom;
      x = r[5:0]; y = r[11:6]; ki = r[12];
      rst_n = (r[23:20] != 4'd0);
      stepc("rand");
    end
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
